// File: rtl/share_serializer_pkg.sv
// Shared constants and state encoding for the share serializer.
// BUSW and STATESHARES mirror the Romulus configuration defaults.
package share_serializer_pkg;

  localparam int STATE_W      = 128;
  localparam int BUSW_DEFAULT = 32;
  localparam int STATESHARES  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/share_serializer_if.sv
// Block-in / word-out handshake bundle of the share serializer.
// slave is the serializer side, master is the side feeding blocks and draining words.
interface share_serializer_if
  import share_serializer_pkg::*;
#(
  parameter int BUSW   = BUSW_DEFAULT,
  parameter int SHARES = STATESHARES
);

  logic [STATE_W*SHARES-1:0] din;
  logic                      din_valid;
  logic                      din_ready;
  logic                      flush;
  logic [BUSW-1:0]           dout;
  logic                      dout_valid;
  logic                      dout_ready;
  logic                      dout_last;
  logic                      busy;

  modport master (
    output din, din_valid, flush, dout_ready,
    input  din_ready, dout, dout_valid, dout_last, busy
  );

  modport slave (
    input  din, din_valid, flush, dout_ready,
    output din_ready, dout, dout_valid, dout_last, busy
  );

endinterface

// File: rtl/share_serializer.sv
// Unloads a masked state held as contiguous shares onto the bus as a
// share-interleaved word stream: word j of share 0..SHARES-1, then word j+1.
module share_serializer
  import share_serializer_pkg::*;
#(
  parameter int BUSW   = BUSW_DEFAULT,
  parameter int SHARES = STATESHARES
) (
  input logic               clk,
  input logic               rst,
  share_serializer_if.slave bus
);

  localparam int WORDS = STATE_W / BUSW;
  localparam int BEATS = SHARES * WORDS;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SLOTS = 2 ** KW;
  localparam logic [KW-1:0] LAST_K = KW'(BEATS - 1);

  ser_state_e                state_reg;
  logic [STATE_W*SHARES-1:0] buf_reg;
  logic [KW-1:0]             k_reg;

  logic                      sending;
  logic                      is_last;
  logic [BUSW-1:0]           beat_words [SLOTS];

  // Beat k maps to share k mod SHARES, word k div SHARES; unused slots read zero.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_beat
      if (gi < BEATS) begin : g_map
        assign beat_words[gi] = buf_reg[STATE_W*(gi % SHARES) + BUSW*(gi / SHARES) +: BUSW];
      end else begin : g_pad
        assign beat_words[gi] = '0;
      end
    end
  endgenerate

  assign sending = (state_reg == SEND);
  assign is_last = sending && (k_reg == LAST_K);

  // buf is zero whenever the block is idle, so dout reads zero without extra gating.
  assign bus.dout       = beat_words[k_reg];
  assign bus.dout_valid = sending;
  assign bus.dout_last  = is_last;
  assign bus.busy       = sending;
  assign bus.din_ready  = !rst && !bus.flush && (!sending || (is_last && bus.dout_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      buf_reg   <= '0;
      k_reg     <= '0;
    end else if (bus.flush) begin
      state_reg <= IDLE;
      buf_reg   <= '0;
      k_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.din_valid) begin
            buf_reg   <= bus.din;
            k_reg     <= '0;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (bus.dout_ready) begin
            if (k_reg != LAST_K) begin
              k_reg <= k_reg + KW'(1);
            end else if (bus.din_valid) begin
              // Back-to-back block: reload on the last beat without a bubble.
              buf_reg <= bus.din;
              k_reg   <= '0;
            end else begin
              state_reg <= IDLE;
              buf_reg   <= '0;
              k_reg     <= '0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
